mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one slow-memory channel between the instruction cache and the data cache. It sits between the two cache `mem_*` ports and a single memory. It holds one granted transaction on the memory side until `mem_ready`, then hands the channel to the other requester with no idle cycle when both are waiting.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_rr_pick2.sv | 25 ++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 28;
   localparam int unsigned DATA_W_DEF = 128;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a conflict the port that is not 'last' wins.
module mem_arbiter_rr_pick2
   import mem_arbiter_pkg::*;
(
   input  logic       req_i,
   input  logic       req_d,
   input  logic       last,
   output logic [1:0] gnt,
   output logic       valid
);

   always_comb begin
      gnt   = 2'b00;
      valid = req_i | req_d;
      if (req_i && req_d) begin
         if (last == PORT_I) gnt[PORT_D] = 1'b1;
         else                gnt[PORT_I] = 1'b1;
      end else if (req_d) begin
         gnt[PORT_D] = 1'b1;
      end else if (req_i) begin
         gnt[PORT_I] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory channel between the I-cache and D-cache.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_wdata,
   output logic [DATA_W-1:0] i_mem_rdata,
   output logic              i_mem_ready,
   input  logic              d_mem_read,
   input  logic              d_mem_write,
   input  logic [ADDR_W-1:0] d_mem_addr,
   input  logic [DATA_W-1:0] d_mem_wdata,
   output logic [DATA_W-1:0] d_mem_rdata,
   output logic              d_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   arb_state_t        state_q, state_d;
   logic              last_q, last_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic       pend_i, pend_d;
   logic       pick_req_i, pick_req_d;
   logic [1:0] pick_gnt;
   logic       pick_valid;

   assign pend_i = i_mem_read | i_mem_write;
   assign pend_d = d_mem_read | d_mem_write;

   // In a grant state only the other port may be picked, and only in the ready cycle.
   always_comb begin
      pick_req_i = 1'b0;
      pick_req_d = 1'b0;
      case (state_q)
         IDLE: begin
            pick_req_i = pend_i;
            pick_req_d = pend_d;
         end
         GNT_I:   pick_req_d = pend_d & mem_ready;
         GNT_D:   pick_req_i = pend_i & mem_ready;
         default: ;
      endcase
   end

   mem_arbiter_rr_pick2 u_rr_pick2 (
      .req_i (pick_req_i),
      .req_d (pick_req_d),
      .last  (last_q),
      .gnt   (pick_gnt),
      .valid (pick_valid)
   );

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state_q     <= IDLE;
         last_q      <= PORT_I;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) state_d = pick_gnt[PORT_D] ? GNT_D : GNT_I;
         end
         GNT_I: begin
            if (mem_ready) state_d = pick_valid ? GNT_D : IDLE;
         end
         GNT_D: begin
            if (mem_ready) state_d = pick_valid ? GNT_I : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory-side request registers and response routing.
   always_comb begin
      last_d      = last_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (pick_valid) begin
         if (pick_gnt[PORT_D]) begin
            last_d      = PORT_D;
            mem_read_d  = d_mem_read;
            mem_write_d = d_mem_write;
            mem_addr_d  = d_mem_addr;
            mem_wdata_d = d_mem_wdata;
         end else if (pick_gnt[PORT_I]) begin
            last_d      = PORT_I;
            mem_read_d  = i_mem_read;
            mem_write_d = i_mem_write;
            mem_addr_d  = i_mem_addr;
            mem_wdata_d = i_mem_wdata;
         end
      end else if ((state_q != IDLE) && mem_ready) begin
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
      end

      i_mem_ready = mem_ready && (state_q == GNT_I);
      d_mem_ready = mem_ready && (state_q == GNT_D);
      i_mem_rdata = (state_q == GNT_I) ? mem_rdata : '0;
      d_mem_rdata = (state_q == GNT_D) ? mem_rdata : '0;
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences, random vs reference model.
module tb_mem_arbiter;

   localparam int unsigned AW = 28;
   localparam int unsigned DW = 128;

   logic          clk = 1'b0;
   logic          proc_reset;
   logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
   logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
   logic [DW-1:0] i_mem_wdata, d_mem_wdata, i_mem_rdata, d_mem_rdata;
   logic          i_mem_ready, d_mem_ready;
   logic          mem_read, mem_write, mem_ready;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk         (clk),
      .proc_reset  (proc_reset),
      .i_mem_read  (i_mem_read),
      .i_mem_write (i_mem_write),
      .i_mem_addr  (i_mem_addr),
      .i_mem_wdata (i_mem_wdata),
      .i_mem_rdata (i_mem_rdata),
      .i_mem_ready (i_mem_ready),
      .d_mem_read  (d_mem_read),
      .d_mem_write (d_mem_write),
      .d_mem_addr  (d_mem_addr),
      .d_mem_wdata (d_mem_wdata),
      .d_mem_rdata (d_mem_rdata),
      .d_mem_ready (d_mem_ready),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic clear_inputs();
      i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_addr = '0;
      d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0;
      i_mem_wdata = {4{32'h1111_1111}};
      d_mem_wdata = {4{32'h2222_2222}};
      mem_ready = 1'b0;
      mem_rdata = {4{32'h3C3C_5A5A}};
   endtask

   task automatic do_reset();
      proc_reset = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      proc_reset = 1'b0;
   endtask

   typedef struct {
      logic          ir, iw;
      logic [AW-1:0] ia;
      logic          dr, dw;
      logic [AW-1:0] da;
      logic          mr;
      logic          er, ew;
      logic [AW-1:0] ea;
      logic          eir, edr;
      int            own;   // 0 none, 1 I, 2 D
   } vec_t;

   vec_t vecs [14];

   // reference model state
   int            m_own, m_last;
   logic          m_rd, m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          r_rd [2], r_wr [2];
   logic [AW-1:0] r_addr [2];
   logic [DW-1:0] r_wd [2];
   logic          done [2];

   task automatic model_step();
      int win;
      logic pi, pd;
      pi  = r_rd[0] | r_wr[0];
      pd  = r_rd[1] | r_wr[1];
      win = -1;
      done[0] = (m_own == 1) && mem_ready;
      done[1] = (m_own == 2) && mem_ready;
      if (m_own == 0) begin
         if (pi && pd) win = (m_last == 0) ? 1 : 0;
         else if (pd)  win = 1;
         else if (pi)  win = 0;
      end else if (mem_ready) begin
         if (m_own == 1 && pd) win = 1;
         else if (m_own == 2 && pi) win = 0;
         else begin
            m_own = 0; m_rd = 1'b0; m_wr = 1'b0;
         end
      end
      if (win >= 0) begin
         m_own = win + 1; m_last = win;
         m_rd = r_rd[win]; m_wr = r_wr[win]; m_addr = r_addr[win]; m_wdata = r_wd[win];
      end
   endtask

   initial begin
      proc_reset = 1'b1;
      clear_inputs();
      #1;
      chk("reset_mem_read", DW'(mem_read), DW'(1'b0));
      chk("reset_mem_write", DW'(mem_write), DW'(1'b0));
      chk("reset_mem_addr", DW'(mem_addr), DW'(0));
      chk("reset_mem_wdata", mem_wdata, '0);
      do_reset();

      // directed table: both-pending D priority, handover, stale guard, spurious ready
      vecs[0]  = '{0,0,28'h00, 0,0,28'h00, 0, 0,0,28'h00, 0,0,0};
      vecs[1]  = '{0,0,28'h00, 0,0,28'h00, 1, 0,0,28'h00, 0,0,0};
      vecs[2]  = '{1,0,28'h30, 0,1,28'h20, 0, 0,0,28'h00, 0,0,0};
      vecs[3]  = '{1,0,28'h30, 0,1,28'h20, 0, 0,1,28'h20, 0,0,2};
      vecs[4]  = '{1,0,28'h30, 0,1,28'h20, 1, 0,1,28'h20, 0,1,2};
      vecs[5]  = '{1,0,28'h30, 0,0,28'h00, 0, 1,0,28'h30, 0,0,1};
      vecs[6]  = '{1,0,28'h30, 0,0,28'h00, 1, 1,0,28'h30, 1,0,1};
      vecs[7]  = '{1,0,28'h40, 0,0,28'h00, 0, 0,0,28'h30, 0,0,0};
      vecs[8]  = '{1,0,28'h40, 0,0,28'h00, 0, 1,0,28'h40, 0,0,1};
      vecs[9]  = '{1,0,28'h40, 1,0,28'h50, 0, 1,0,28'h40, 0,0,1};
      vecs[10] = '{1,0,28'h40, 1,0,28'h50, 1, 1,0,28'h40, 1,0,1};
      vecs[11] = '{0,0,28'h00, 1,0,28'h50, 1, 1,0,28'h50, 0,1,2};
      vecs[12] = '{0,1,28'h70, 0,1,28'h60, 0, 0,0,28'h50, 0,0,0};
      vecs[13] = '{0,1,28'h70, 0,1,28'h60, 0, 0,1,28'h70, 0,0,1};
      for (int k = 0; k < 14; k++) begin
         i_mem_read = vecs[k].ir; i_mem_write = vecs[k].iw; i_mem_addr = vecs[k].ia;
         d_mem_read = vecs[k].dr; d_mem_write = vecs[k].dw; d_mem_addr = vecs[k].da;
         mem_ready  = vecs[k].mr;
         settle();
         chk($sformatf("vec%0d_mem_read", k), DW'(mem_read), DW'(vecs[k].er));
         chk($sformatf("vec%0d_mem_write", k), DW'(mem_write), DW'(vecs[k].ew));
         chk($sformatf("vec%0d_mem_addr", k), DW'(mem_addr), DW'(vecs[k].ea));
         chk($sformatf("vec%0d_i_ready", k), DW'(i_mem_ready), DW'(vecs[k].eir));
         chk($sformatf("vec%0d_d_ready", k), DW'(d_mem_ready), DW'(vecs[k].edr));
         chk($sformatf("vec%0d_i_rdata", k), i_mem_rdata, (vecs[k].own == 1) ? mem_rdata : '0);
         chk($sformatf("vec%0d_d_rdata", k), d_mem_rdata, (vecs[k].own == 2) ? mem_rdata : '0);
         if (vecs[k].own != 0)
            chk($sformatf("vec%0d_wdata", k), mem_wdata, (vecs[k].own == 1) ? i_mem_wdata : d_mem_wdata);
         next_cycle();
      end

      // single I read answered after 7 cycles
      do_reset();
      i_mem_read = 1'b1; i_mem_addr = 28'h0000010; mem_rdata = {16{8'hA5}};
      next_cycle();
      settle();
      chk("single_mem_read", DW'(mem_read), DW'(1'b1));
      chk("single_mem_addr", DW'(mem_addr), DW'(28'h0000010));
      for (int c = 2; c < 7; c++) begin
         next_cycle();
         settle();
         chk($sformatf("single_wait%0d_i_ready", c), DW'(i_mem_ready), DW'(1'b0));
      end
      next_cycle();
      mem_ready = 1'b1;
      settle();
      chk("single_i_ready", DW'(i_mem_ready), DW'(1'b1));
      chk("single_i_rdata", i_mem_rdata, {16{8'hA5}});
      chk("single_d_ready", DW'(d_mem_ready), DW'(1'b0));
      next_cycle();
      mem_ready = 1'b0; i_mem_read = 1'b0;
      settle();
      chk("single_after_mem_read", DW'(mem_read), DW'(1'b0));

      // continuous contention: one-cycle transactions, strict D,I,D,I alternation
      do_reset();
      i_mem_read = 1'b1;  i_mem_addr = 28'h100;
      d_mem_write = 1'b1; d_mem_addr = 28'h200;
      next_cycle();
      for (int k = 0; k < 8; k++) begin
         logic exp_d;
         exp_d = ((k % 2) == 0);
         mem_ready = 1'b1;
         settle();
         chk($sformatf("rr%0d_mem_write", k), DW'(mem_write), DW'(exp_d));
         chk($sformatf("rr%0d_mem_read", k), DW'(mem_read), DW'(!exp_d));
         chk($sformatf("rr%0d_mem_addr", k), DW'(mem_addr),
             exp_d ? DW'(28'h200 + 28'(k / 2)) : DW'(28'h100 + 28'(k / 2)));
         chk($sformatf("rr%0d_d_ready", k), DW'(d_mem_ready), DW'(exp_d));
         next_cycle();
         if (exp_d) d_mem_addr = 28'h200 + 28'(k / 2 + 1);
         else       i_mem_addr = 28'h100 + 28'(k / 2 + 1);
      end
      mem_ready = 1'b0;

      // reset in the middle of a D transaction, then D priority again
      do_reset();
      d_mem_read = 1'b1; d_mem_addr = 28'h80;
      next_cycle();
      settle();
      chk("rstmid_granted", DW'(mem_read), DW'(1'b1));
      i_mem_read = 1'b1; i_mem_addr = 28'h90; mem_ready = 1'b1;
      proc_reset = 1'b1;
      #1;
      chk("rstmid_mem_read", DW'(mem_read), DW'(1'b0));
      chk("rstmid_mem_addr", DW'(mem_addr), DW'(0));
      chk("rstmid_mem_wdata", mem_wdata, '0);
      chk("rstmid_d_ready", DW'(d_mem_ready), DW'(1'b0));
      chk("rstmid_d_rdata", d_mem_rdata, '0);
      next_cycle();
      proc_reset = 1'b0; mem_ready = 1'b0;
      next_cycle();
      settle();
      chk("rstmid_regrant_read", DW'(mem_read), DW'(1'b1));
      chk("rstmid_regrant_addr", DW'(mem_addr), DW'(28'h80));

      // randomized traffic against the reference model
      do_reset();
      m_own = 0; m_last = 0; m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
      for (int p = 0; p < 2; p++) begin
         r_rd[p] = 1'b0; r_wr[p] = 1'b0; r_addr[p] = '0; r_wd[p] = '0; done[p] = 1'b0;
      end
      for (int n = 0; n < 3000; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (!(r_rd[p] | r_wr[p]) || done[p]) begin
               r_rd[p] = 1'b0; r_wr[p] = 1'b0;
               if ($urandom_range(1, 0) == 1) begin
                  if ($urandom_range(1, 0) == 1) r_rd[p] = 1'b1;
                  else                           r_wr[p] = 1'b1;
                  r_addr[p] = AW'($urandom);
                  r_wd[p]   = {$urandom, $urandom, $urandom, $urandom};
               end
            end
         end
         i_mem_read = r_rd[0]; i_mem_write = r_wr[0]; i_mem_addr = r_addr[0]; i_mem_wdata = r_wd[0];
         d_mem_read = r_rd[1]; d_mem_write = r_wr[1]; d_mem_addr = r_addr[1]; d_mem_wdata = r_wd[1];
         mem_ready = ($urandom_range(2, 0) == 0);
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         settle();
         chk("rnd_mem_read", DW'(mem_read), DW'(m_rd));
         chk("rnd_mem_write", DW'(mem_write), DW'(m_wr));
         chk("rnd_mem_addr", DW'(mem_addr), DW'(m_addr));
         chk("rnd_mem_wdata", mem_wdata, m_wdata);
         chk("rnd_i_ready", DW'(i_mem_ready), DW'(mem_ready && m_own == 1));
         chk("rnd_d_ready", DW'(d_mem_ready), DW'(mem_ready && m_own == 2));
         chk("rnd_i_rdata", i_mem_rdata, (m_own == 1) ? mem_rdata : '0);
         chk("rnd_d_rdata", d_mem_rdata, (m_own == 2) ? mem_rdata : '0);
         model_step();
         next_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
